key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 125 ++++++++++++
 tb/tb_key_conditioner.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Four-key push-button conditioner: synchronize, debounce, press/release edges, auto-repeat or long-press.
// Note: the release pulse port is named rel because release is a reserved word.
module key_conditioner #(
  parameter int         DEBOUNCE_CYC = 1000000,
  parameter int         HOLD_CYC     = 25000000,
  parameter int         REPEAT_CYC   = 5000000,
  parameter logic [3:0] REPEAT_MASK  = 4'b0011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_n,
  output logic [3:0] level,
  output logic [3:0] press,
  output logic [3:0] rel,
  output logic [3:0] rpt,
  output logic [3:0] long
);

  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int RW = $clog2(REPEAT_CYC + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] HOLD   = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;
  localparam logic [1:0] HELD   = 2'd3;

  logic [3:0]    sync1, sync2;
  logic [DW-1:0] db_cnt   [4];
  logic [HW-1:0] hold_cnt [4];
  logic [RW-1:0] rep_cnt  [4];
  logic [1:0]    state    [4];
  logic [3:0]    db_hit, rise, fall;

  // db_hit marks the cycle the debounce counter would reach DEBOUNCE_CYC.
  always_comb begin
    db_hit = '0;
    rise   = '0;
    fall   = '0;
    for (int i = 0; i < 4; i++) begin
      db_hit[i] = ((~sync2[i]) != level[i]) && (db_cnt[i] == DB_LAST);
      rise[i]   = db_hit[i] && !level[i];
      fall[i]   = db_hit[i] && level[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      level <= '0;
      press <= '0;
      rel   <= '0;
      rpt   <= '0;
      long  <= '0;
      for (int i = 0; i < 4; i++) begin
        db_cnt[i]   <= '0;
        hold_cnt[i] <= '0;
        rep_cnt[i]  <= '0;
        state[i]    <= IDLE;
      end
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      for (int i = 0; i < 4; i++) begin
        press[i] <= rise[i];
        rel[i]   <= fall[i];
        rpt[i]   <= 1'b0;
        long[i]  <= 1'b0;

        if (db_hit[i]) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else if ((~sync2[i]) != level[i]) begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end else begin
          db_cnt[i] <= '0;
        end

        // A falling level overrides any hold/repeat threshold landing on the same cycle.
        if (fall[i]) begin
          state[i] <= IDLE;
        end else begin
          case (state[i])
            IDLE: begin
              if (rise[i]) begin
                state[i]    <= HOLD;
                hold_cnt[i] <= '0;
              end
            end
            HOLD: begin
              if (hold_cnt[i] == HOLD_LAST) begin
                hold_cnt[i] <= '0;
                rep_cnt[i]  <= '0;
                if (REPEAT_MASK[i]) begin
                  state[i] <= REPEAT;
                  rpt[i]   <= 1'b1;
                end else begin
                  state[i] <= HELD;
                  long[i]  <= 1'b1;
                end
              end else begin
                hold_cnt[i] <= hold_cnt[i] + 1'b1;
              end
            end
            REPEAT: begin
              if (rep_cnt[i] == REP_LAST) begin
                rep_cnt[i] <= '0;
                rpt[i]     <= 1'b1;
              end else begin
                rep_cnt[i] <= rep_cnt[i] + 1'b1;
              end
            end
            default: state[i] <= HELD;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed and randomized checks of key_conditioner against a time-based reference model.
module tb_key_conditioner;
  localparam int         D = 4;
  localparam int         H = 10;
  localparam int         R = 3;
  localparam logic [3:0] M = 4'b0011;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_n = 4'hf;
  logic [3:0] level, press, rel, rpt, long;

  always #5 clk = ~clk;

  key_conditioner #(
    .DEBOUNCE_CYC(D), .HOLD_CYC(H), .REPEAT_CYC(R), .REPEAT_MASK(M)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n),
    .level(level), .press(press), .rel(rel), .rpt(rpt), .long(long)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: synchronizer delay, run-length debounce, hold/repeat from elapsed time since press.
  logic [3:0] m_s1, m_s2, m_lvl, m_press, m_rel, m_rpt, m_long;
  logic [3:0] mask;
  int m_run [4];
  int m_pt  [4];
  int t = 0;

  // Observed DUT pulse bookkeeping for directed checks.
  int n_press [4], n_rel [4], n_rpt [4], n_long [4];
  int t_press [4], t_rel [4], t_rpt1 [4], t_rptl [4], t_long [4];

  task automatic clear_obs();
    for (int i = 0; i < 4; i++) begin
      n_press[i] = 0; n_rel[i] = 0; n_rpt[i] = 0; n_long[i] = 0;
      t_press[i] = -1; t_rel[i] = -1; t_rpt1[i] = -1; t_rptl[i] = -1; t_long[i] = -1;
    end
  endtask

  task automatic model_reset();
    m_s1 = 4'hf; m_s2 = 4'hf; m_lvl = '0;
    m_press = '0; m_rel = '0; m_rpt = '0; m_long = '0;
    for (int i = 0; i < 4; i++) begin
      m_run[i] = 0;
      m_pt[i]  = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] k);
    m_press = '0; m_rel = '0; m_rpt = '0; m_long = '0;
    for (int i = 0; i < 4; i++) begin
      if ((!m_s2[i]) != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_lvl[i] = ~m_lvl[i];
          m_run[i] = 0;
          if (m_lvl[i]) begin
            m_press[i] = 1'b1;
            m_pt[i]    = t;
          end else begin
            m_rel[i] = 1'b1;
          end
        end
      end else begin
        m_run[i] = 0;
      end
      if (m_lvl[i] && !m_press[i]) begin
        int d;
        d = t - m_pt[i];
        if (mask[i]) m_rpt[i] = (d >= H) && (((d - H) % R) == 0);
        else         m_long[i] = (d == H);
      end
    end
    m_s2 = m_s1;
    m_s1 = k;
  endtask

  task automatic cycle();
    @(posedge clk);
    t++;
    if (reset) model_reset();
    else       model_step(key_n);
    #1;
    chk("level", level, m_lvl);
    chk("press", press, m_press);
    chk("release", rel, m_rel);
    chk("rpt", rpt, m_rpt);
    chk("long", long, m_long);
    for (int i = 0; i < 4; i++) begin
      if (press[i]) begin n_press[i]++; t_press[i] = t; end
      if (rel[i])   begin n_rel[i]++;   t_rel[i]   = t; end
      if (long[i])  begin n_long[i]++;  t_long[i]  = t; end
      if (rpt[i]) begin
        if (n_rpt[i] == 0) t_rpt1[i] = t;
        n_rpt[i]++;
        t_rptl[i] = t;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic wait_press(input int k);
    for (int c = 0; c < 20 && t_press[k] < 0; c++) cycle();
  endtask

  task automatic check_idle_now(input string tag);
    #1;
    chk(tag, {level, press, rel, rpt, long}, 0);
  endtask

  int t0;

  initial begin
    mask = M;
    model_reset();
    clear_obs();
    check_idle_now("reset_outputs");
    run(3);
    reset = 1'b0;
    run(5);

    // Clean press on key 0: level/press after 6 cycles, then repeat cadence, then release.
    clear_obs();
    key_n[0] = 1'b0; t0 = t;
    wait_press(0);
    chk("press0_latency", t_press[0] - t0, 6);
    chk("press0_level", level[0], 1);
    run(20);
    chk("rpt0_first", t_rpt1[0] - t_press[0], 10);
    chk("rpt0_count", n_rpt[0], 1 + (t - t_press[0] - H) / R);
    key_n[0] = 1'b1; t0 = t;
    run(15);
    chk("rel0_latency", t_rel[0] - t0, 6);
    chk("rel0_no_rpt_after", t_rptl[0] < t_rel[0], 1);

    // 3-cycle glitch on key 1 must be invisible.
    clear_obs();
    key_n[1] = 1'b0;
    run(3);
    key_n[1] = 1'b1;
    run(15);
    chk("glitch1_press", n_press[1], 0);
    chk("glitch1_release", n_rel[1], 0);

    // Key 3 is a long-press key: one long pulse, no repeats.
    clear_obs();
    key_n[3] = 1'b0;
    run(30);
    key_n[3] = 1'b1;
    run(15);
    chk("long3_count", n_long[3], 1);
    chk("long3_delay", t_long[3] - t_press[3], 10);
    chk("rpt3_count", n_rpt[3], 0);

    // Keys 0 and 2 together; key 2 release must not disturb key 0's cadence.
    clear_obs();
    key_n[0] = 1'b0; key_n[2] = 1'b0;
    wait_press(0);
    chk("press02_same", t_press[2], t_press[0]);
    run(20);
    key_n[2] = 1'b1;
    run(20);
    chk("rpt0_cadence", (t_rptl[0] - t_press[0] - H) % R, 0);
    chk("rpt0_count2", n_rpt[0], 1 + (t_rptl[0] - t_press[0] - H) / R);
    key_n[0] = 1'b1;
    run(15);

    // Reset while key 0 is repeating and still held.
    clear_obs();
    key_n[0] = 1'b0;
    run(30);
    reset = 1'b1;
    check_idle_now("reset_async_clear");
    clear_obs();
    run(3);
    reset = 1'b0; t0 = t;
    wait_press(0);
    chk("reset_no_release", n_rel[0], 0);
    chk("repress0_latency", t_press[0] - t0, 6);
    run(12);
    chk("rpt0_after_reset", t_rpt1[0] - t_press[0], 10);
    key_n[0] = 1'b1;
    run(15);

    // Randomized key activity with occasional resets, checked cycle-by-cycle by the model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) key_n[i] = ~key_n[i];
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
